// File: rtl/ebus_pkg.sv
// Shared definitions for the Z80-style external bus master: command
// encodings, FSM state codes, parameter bounds and small op decoders.
package ebus_pkg;

  localparam logic [2:0] OP_MEMRD   = 3'd0;
  localparam logic [2:0] OP_MEMWR   = 3'd1;
  localparam logic [2:0] OP_IORD    = 3'd2;
  localparam logic [2:0] OP_IOWR    = 3'd3;
  localparam logic [2:0] OP_ACQUIRE = 3'd4;
  localparam logic [2:0] OP_RELEASE = 3'd5;

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_REQ  = 4'd1;
  localparam logic [3:0] ST_OWN  = 4'd2;
  localparam logic [3:0] ST_T1   = 4'd3;
  localparam logic [3:0] ST_T2   = 4'd4;
  localparam logic [3:0] ST_TW   = 4'd5;
  localparam logic [3:0] ST_T3   = 4'd6;
  localparam logic [3:0] ST_HOLD = 4'd7;
  localparam logic [3:0] ST_REL  = 4'd8;

  localparam int WAIT_STATES_MAX = 7;
  localparam int ACQ_TIMEOUT_MIN = 1;
  localparam int ACQ_TIMEOUT_MAX = 255;

  function automatic logic op_is_bus(input logic [2:0] op);
    return (op == OP_MEMRD) || (op == OP_MEMWR) || (op == OP_IORD) || (op == OP_IOWR);
  endfunction

  function automatic logic op_is_write(input logic [2:0] op);
    return (op == OP_MEMWR) || (op == OP_IOWR);
  endfunction

  function automatic logic op_is_io(input logic [2:0] op);
    return (op == OP_IORD) || (op == OP_IOWR);
  endfunction

endpackage

// File: rtl/ebus_sync2.sv
// Two-flop synchroniser for asynchronous bus handshake inputs. The reset
// value is a parameter so inactive-high strobes come out of reset idle.
module ebus_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the async input through two flops before anyone looks at it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ebus_cycle_master.sv
// Z80-style external bus master. Accepts acquire/release and mem/IO
// read/write commands, owns the BUSREQ/BUSACK handshake and generates
// phi-synchronous T1/T2/Tw/T3 cycles with fixed plus requested wait states.
module ebus_cycle_master
  import ebus_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 0,
  parameter int ACQ_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              phi_rise,
  input  logic              phi_fall,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wrdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rddata,
  output logic              busreq_n,
  input  logic              busack_n,
  input  logic              wait_n,
  output logic [ADDR_W-1:0] bus_a,
  output logic [DATA_W-1:0] bus_d_out,
  input  logic [DATA_W-1:0] bus_d_in,
  output logic              bus_a_oe,
  output logic              bus_d_oe,
  output logic              bus_rd_n,
  output logic              bus_wr_n,
  output logic              bus_mreq_n,
  output logic              bus_iorq_n
);

  // Out-of-range parameters are clamped into the supported window
  localparam int WAIT_EFF = (WAIT_STATES < 0) ? 0 :
                            (WAIT_STATES > WAIT_STATES_MAX) ? WAIT_STATES_MAX : WAIT_STATES;
  localparam int ACQ_EFF  = (ACQ_TIMEOUT < ACQ_TIMEOUT_MIN) ? ACQ_TIMEOUT_MIN :
                            (ACQ_TIMEOUT > ACQ_TIMEOUT_MAX) ? ACQ_TIMEOUT_MAX : ACQ_TIMEOUT;
  localparam logic [7:0] WAIT_LIM = 8'(WAIT_EFF);
  localparam logic [7:0] ACQ_LIM  = 8'(ACQ_EFF);

  logic              busack_s;
  logic              wait_s;
  logic [3:0]        state;
  logic [7:0]        cnt;
  logic              ready_en;
  logic              wait_hold;
  logic              done_flag;
  logic [2:0]        lat_op;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              rise;
  logic              fall;
  logic              accept;

  ebus_sync2 #(.RST_VAL(1'b1)) u_sync_busack (
    .clk   (clk),
    .reset (reset),
    .d     (busack_n),
    .q     (busack_s)
  );

  ebus_sync2 #(.RST_VAL(1'b1)) u_sync_wait (
    .clk   (clk),
    .reset (reset),
    .d     (wait_n),
    .q     (wait_s)
  );

  // phi_rise takes priority if both strobes ever arrive together
  assign rise = phi_rise;
  assign fall = phi_fall & ~phi_rise;

  // Commands are taken only when idle or owning the bus with the grant still held,
  // so a grant loss in OWN can never swallow a command without a response
  assign cmd_ready = ready_en && ((state == ST_IDLE) || ((state == ST_OWN) && !busack_s));
  assign accept    = cmd_valid && cmd_ready;

  // Single FSM: bus handshake, T-state sequencing, strobes and responses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= 8'd0;
      ready_en   <= 1'b0;
      wait_hold  <= 1'b0;
      done_flag  <= 1'b0;
      lat_op     <= OP_MEMRD;
      lat_addr   <= '0;
      lat_data   <= '0;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rddata <= '0;
      busreq_n   <= 1'b1;
      bus_a      <= '0;
      bus_d_out  <= '0;
      bus_a_oe   <= 1'b0;
      bus_d_oe   <= 1'b0;
      bus_rd_n   <= 1'b1;
      bus_wr_n   <= 1'b1;
      bus_mreq_n <= 1'b1;
      bus_iorq_n <= 1'b1;
    end else begin
      ready_en  <= 1'b1;
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (cmd_op == OP_ACQUIRE) begin
              busreq_n <= 1'b0;
              cnt      <= 8'd0;
              state    <= ST_REQ;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= (cmd_op != OP_RELEASE);
            end
          end
        end
        ST_REQ: begin
          if (!busack_s) begin
            bus_a_oe  <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            state     <= ST_OWN;
          end else if (rise) begin
            if (cnt == ACQ_LIM - 8'd1) begin
              busreq_n  <= 1'b1;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
        end
        ST_OWN: begin
          if (busack_s) begin
            bus_a_oe <= 1'b0;
            bus_d_oe <= 1'b0;
            busreq_n <= 1'b1;
            state    <= ST_IDLE;
          end else if (accept) begin
            if (cmd_op == OP_ACQUIRE) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
            end else if (cmd_op == OP_RELEASE) begin
              bus_a_oe <= 1'b0;
              state    <= ST_REL;
            end else if (op_is_bus(cmd_op)) begin
              lat_op   <= cmd_op;
              lat_addr <= cmd_addr;
              lat_data <= cmd_wrdata;
              cnt      <= 8'd0;
              state    <= ST_T1;
            end else begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end
          end
        end
        ST_T1: begin
          if (rise) begin
            if (cnt == 8'd0) begin
              bus_a <= lat_addr;
              cnt   <= 8'd1;
            end else begin
              cnt       <= 8'd0;
              wait_hold <= 1'b0;
              state     <= ST_T2;
              if (op_is_write(lat_op)) begin
                bus_wr_n  <= 1'b0;
                bus_d_oe  <= 1'b1;
                bus_d_out <= lat_data;
              end else begin
                bus_rd_n <= 1'b0;
              end
            end
          end
        end
        ST_T2: begin
          if (rise) begin
            cnt <= 8'd1;
            if ((WAIT_LIM != 8'd0) || wait_hold) begin
              state <= ST_TW;
            end else begin
              state <= ST_T3;
            end
          end else if (fall) begin
            if (op_is_io(lat_op)) begin
              bus_iorq_n <= 1'b0;
            end else begin
              bus_mreq_n <= 1'b0;
            end
            wait_hold <= !wait_s;
          end
        end
        ST_TW: begin
          if (rise) begin
            if (cnt < WAIT_LIM) begin
              cnt <= cnt + 8'd1;
            end else if (!wait_hold) begin
              state <= ST_T3;
            end
          end else if (fall) begin
            wait_hold <= !wait_s;
          end
        end
        ST_T3: begin
          if (done_flag) begin
            done_flag <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            state     <= op_is_write(lat_op) ? ST_HOLD : ST_OWN;
          end else if (fall) begin
            bus_rd_n   <= 1'b1;
            bus_wr_n   <= 1'b1;
            bus_mreq_n <= 1'b1;
            bus_iorq_n <= 1'b1;
            done_flag  <= 1'b1;
            if (!op_is_write(lat_op)) begin
              rsp_rddata <= bus_d_in;
            end
          end
        end
        ST_HOLD: begin
          if (rise) begin
            bus_d_oe <= 1'b0;
            state    <= ST_OWN;
          end
        end
        ST_REL: begin
          if (rise) begin
            busreq_n  <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ebus_cycle_master.sv
// Scoreboard bench for ebus_cycle_master: phi runs at clk/4 (rise at phase 0,
// fall at phase 2), the bench plays the bus arbiter and the wait-state source.
module tb_ebus_cycle_master;
  import ebus_pkg::*;

  typedef struct {
    string      tag;
    logic       err;
    logic [7:0] data;
    logic       chk;
  } exp_t;

  typedef struct {
    int          rd_w;
    int          wr_w;
    int          mreq_w;
    int          iorq_w;
    logic [15:0] a;
    logic [7:0]  d;
    logic        doe;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  phase = 2'd0;
  logic        phi_rise, phi_fall;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [15:0] cmd_addr = 16'h0;
  logic [7:0]  cmd_wrdata = 8'h0;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_rddata;
  logic        busreq_n;
  logic        busack_n = 1'b1;
  logic        wait_n = 1'b1;
  logic [15:0] bus_a;
  logic [7:0]  bus_d_out;
  logic [7:0]  bus_d_in = 8'h0;
  logic        bus_a_oe, bus_d_oe, bus_rd_n, bus_wr_n, bus_mreq_n, bus_iorq_n;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   rise_cnt = 0;
  logic last_rise = 1'b0;
  int   rsp_cnt = 0;
  int   rsp_cyc = 0;
  int   rsp_rise = 0;
  int   acc_rise = 0;
  exp_t exp_q[$];

  ebus_cycle_master #(
    .ADDR_W      (16),
    .DATA_W      (8),
    .WAIT_STATES (1),
    .ACQ_TIMEOUT (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .phi_rise   (phi_rise),
    .phi_fall   (phi_fall),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_wrdata (cmd_wrdata),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_rddata (rsp_rddata),
    .busreq_n   (busreq_n),
    .busack_n   (busack_n),
    .wait_n     (wait_n),
    .bus_a      (bus_a),
    .bus_d_out  (bus_d_out),
    .bus_d_in   (bus_d_in),
    .bus_a_oe   (bus_a_oe),
    .bus_d_oe   (bus_d_oe),
    .bus_rd_n   (bus_rd_n),
    .bus_wr_n   (bus_wr_n),
    .bus_mreq_n (bus_mreq_n),
    .bus_iorq_n (bus_iorq_n)
  );

  always #5 clk = ~clk;

  assign phi_rise = (phase == 2'd0);
  assign phi_fall = (phase == 2'd2);

  // Free-running phi phase plus cycle and phi-rise counters for latency checks
  always @(posedge clk) begin
    phase     <= phase + 2'd1;
    cyc       <= cyc + 1;
    last_rise <= phi_rise;
    if (phi_rise) rise_cnt <= rise_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every response pops the oldest expectation and compares it
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      rsp_cnt  <= rsp_cnt + 1;
      rsp_cyc  <= cyc;
      rsp_rise <= rise_cnt;
      if (exp_q.size() == 0) begin
        checkOutput("rsp_without_cmd", 32'(rsp_valid), 32'd0);
      end else begin
        checkOutput({exp_q[0].tag, "_err"}, 32'(rsp_err), 32'(exp_q[0].err));
        if (exp_q[0].chk) checkOutput({exp_q[0].tag, "_rddata"}, 32'(rsp_rddata), 32'(exp_q[0].data));
        void'(exp_q.pop_front());
      end
    end
  end

  // Watchdog so a stuck handshake still ends the run
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic applyStimulus(input logic [2:0] op, input logic [15:0] addr, input logic [7:0] wd,
                               input logic e_err, input logic [7:0] e_data, input logic e_chk,
                               input string tag);
    int guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      checkOutput({tag, "_ready_timeout"}, 32'(cmd_ready), 32'd1);
    end else begin
      exp_q.push_back('{tag, e_err, e_data, e_chk});
      cmd_valid  = 1'b1;
      cmd_op     = op;
      cmd_addr   = addr;
      cmd_wrdata = wd;
      @(posedge clk);
      #1;
      acc_rise   = rise_cnt;
      cmd_valid  = 1'b0;
      cmd_addr   = 16'(~addr);
      cmd_wrdata = 8'(~wd);
    end
  endtask

  task automatic waitRsp(input string tag, input int n_before, input int wait_rel, output obs_t o);
    int guard = 0;
    int since = 0;
    bit seen  = 1'b0;
    o = '{default: 0};
    while (rsp_cnt == n_before && guard < 400) begin
      @(negedge clk);
      if (!bus_rd_n)   o.rd_w++;
      if (!bus_wr_n)   o.wr_w++;
      if (!bus_mreq_n) o.mreq_w++;
      if (!bus_iorq_n) o.iorq_w++;
      if (!seen && (!bus_rd_n || !bus_wr_n)) begin
        seen  = 1'b1;
        since = 0;
        o.a   = bus_a;
        o.d   = bus_d_out;
        o.doe = bus_d_oe;
      end else if (seen) begin
        since++;
      end
      if (seen && wait_rel >= 0 && since == wait_rel) wait_n = 1'b1;
      #1;
      guard++;
    end
    if (rsp_cnt == n_before) checkOutput({tag, "_rsp_timeout"}, rsp_cnt, n_before + 1);
  endtask

  task automatic doCmd(input logic [2:0] op, input logic [15:0] addr, input logic [7:0] wd,
                       input logic e_err, input logic [7:0] e_data, input logic e_chk,
                       input string tag, input int wait_rel, output obs_t o);
    int n = rsp_cnt;
    applyStimulus(op, addr, wd, e_err, e_data, e_chk, tag);
    waitRsp(tag, n, wait_rel, o);
  endtask

  task automatic acquireBus(input string tag);
    obs_t o;
    int n = rsp_cnt;
    applyStimulus(OP_ACQUIRE, 16'h0, 8'h0, 1'b0, 8'h0, 1'b0, tag);
    repeat (8) @(posedge clk);
    #1 busack_n = 1'b0;
    waitRsp(tag, n, -1, o);
  endtask

  initial begin
    obs_t o;
    int   n;
    int   c0;
    int   guard;

    $display("[TB] reset phase");
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busreq_n", 32'(busreq_n), 32'd1);
    checkOutput("rst_strobes", 32'({bus_rd_n, bus_wr_n, bus_mreq_n, bus_iorq_n}), 32'hF);
    checkOutput("rst_oe", 32'({bus_a_oe, bus_d_oe}), 32'd0);
    checkOutput("rst_bus_a", 32'(bus_a), 32'd0);
    checkOutput("rst_bus_d_out", 32'(bus_d_out), 32'd0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    checkOutput("rst_rsp", 32'({rsp_valid, rsp_err}), 32'd0);
    checkOutput("rst_rddata", 32'(rsp_rddata), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] commands while idle");
    doCmd(OP_MEMWR, 16'h1000, 8'h55, 1'b1, 8'h0, 1'b0, "idle_memwr", -1, o);
    checkOutput("idle_memwr_no_strobes", o.rd_w + o.wr_w + o.mreq_w + o.iorq_w, 0);
    checkOutput("idle_memwr_busreq_n", 32'(busreq_n), 32'd1);
    checkOutput("idle_memwr_a_oe", 32'(bus_a_oe), 32'd0);
    doCmd(3'd6, 16'h0, 8'h0, 1'b1, 8'h0, 1'b0, "idle_illegal", -1, o);
    doCmd(OP_RELEASE, 16'h0, 8'h0, 1'b0, 8'h0, 1'b0, "idle_release", -1, o);

    $display("[TB] acquire with no grant");
    n = rsp_cnt;
    applyStimulus(OP_ACQUIRE, 16'h0, 8'h0, 1'b1, 8'h0, 1'b0, "acq_timeout");
    checkOutput("acq_timeout_busreq_low", 32'(busreq_n), 32'd0);
    waitRsp("acq_timeout", n, -1, o);
    checkOutput("acq_timeout_phi_rises", rsp_rise - acc_rise, 4);
    checkOutput("acq_timeout_busreq_n", 32'(busreq_n), 32'd1);

    $display("[TB] acquire with grant two phi later");
    n = rsp_cnt;
    applyStimulus(OP_ACQUIRE, 16'h0, 8'h0, 1'b0, 8'h0, 1'b0, "acq_ok");
    repeat (8) @(posedge clk);
    #1 busack_n = 1'b0;
    c0 = cyc;
    waitRsp("acq_ok", n, -1, o);
    checkOutput("acq_ok_latency", rsp_cyc - c0, 3);
    checkOutput("acq_ok_busreq_n", 32'(busreq_n), 32'd0);
    checkOutput("acq_ok_a_oe", 32'(bus_a_oe), 32'd1);
    checkOutput("acq_ok_strobes", 32'({bus_rd_n, bus_wr_n, bus_mreq_n, bus_iorq_n}), 32'hF);

    doCmd(OP_ACQUIRE, 16'h0, 8'h0, 1'b0, 8'h0, 1'b0, "own_acquire", -1, o);
    doCmd(3'd7, 16'h0, 8'h0, 1'b1, 8'h0, 1'b0, "own_illegal", -1, o);

    $display("[TB] io write");
    doCmd(OP_IOWR, 16'h00EC, 8'h80, 1'b0, 8'h0, 1'b0, "iowr", -1, o);
    checkOutput("iowr_addr", 32'(o.a), 32'h00EC);
    checkOutput("iowr_data", 32'(o.d), 32'h80);
    checkOutput("iowr_doe_at_wr", 32'(o.doe), 32'd1);
    checkOutput("iowr_wr_width", o.wr_w, 10);
    checkOutput("iowr_iorq_width", o.iorq_w, 8);
    checkOutput("iowr_rd_mreq_idle", o.rd_w + o.mreq_w, 0);
    checkOutput("iowr_doe_held", 32'(bus_d_oe), 32'd1);
    guard = 0;
    while (bus_d_oe && guard < 12) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("iowr_doe_drop", 32'(bus_d_oe), 32'd0);
    checkOutput("iowr_doe_drop_at_rise", 32'(last_rise), 32'd1);

    $display("[TB] memory reads");
    bus_d_in = 8'h5A;
    doCmd(OP_MEMRD, 16'h3000, 8'h0, 1'b0, 8'h5A, 1'b1, "memrd", -1, o);
    checkOutput("memrd_addr", 32'(o.a), 32'h3000);
    checkOutput("memrd_rd_width", o.rd_w, 10);
    checkOutput("memrd_mreq_width", o.mreq_w, 8);
    checkOutput("memrd_wr_iorq_idle", o.wr_w + o.iorq_w, 0);

    wait_n   = 1'b0;
    bus_d_in = 8'hC3;
    doCmd(OP_MEMRD, 16'h1234, 8'h0, 1'b0, 8'hC3, 1'b1, "memrd_wait", 10, o);
    checkOutput("memrd_wait_addr", 32'(o.a), 32'h1234);
    checkOutput("memrd_wait_rd_width", o.rd_w, 18);
    checkOutput("memrd_wait_mreq_width", o.mreq_w, 16);

    bus_d_in = 8'h99;
    doCmd(OP_IORD, 16'h0042, 8'h0, 1'b0, 8'h99, 1'b1, "iord", -1, o);
    checkOutput("iord_iorq_width", o.iorq_w, 8);
    checkOutput("iord_rd_width", o.rd_w, 10);
    checkOutput("iord_mreq_idle", o.mreq_w, 0);

    $display("[TB] release and grant loss");
    doCmd(OP_RELEASE, 16'h0, 8'h0, 1'b0, 8'h0, 1'b0, "own_release", -1, o);
    checkOutput("own_release_busreq_n", 32'(busreq_n), 32'd1);
    checkOutput("own_release_a_oe", 32'(bus_a_oe), 32'd0);
    busack_n = 1'b1;
    repeat (4) @(posedge clk);

    acquireBus("acq2");
    busack_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("ack_loss_a_oe", 32'(bus_a_oe), 32'd0);
    checkOutput("ack_loss_busreq_n", 32'(busreq_n), 32'd1);
    checkOutput("ack_loss_ready", 32'(cmd_ready), 32'd1);

    $display("[TB] reset during T2");
    acquireBus("acq3");
    applyStimulus(OP_MEMWR, 16'h4000, 8'h11, 1'b0, 8'h0, 1'b0, "rst_memwr");
    guard = 0;
    while (bus_wr_n && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("rst_mid_t2_reached", 32'(bus_wr_n), 32'd0);
    checkOutput("rst_mid_t2_doe_before", 32'(bus_d_oe), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_t2_oe", 32'({bus_a_oe, bus_d_oe}), 32'd0);
    checkOutput("rst_mid_t2_busreq_n", 32'(busreq_n), 32'd1);
    checkOutput("rst_mid_t2_strobes", 32'({bus_rd_n, bus_wr_n, bus_mreq_n, bus_iorq_n}), 32'hF);
    checkOutput("rst_mid_t2_bus_a", 32'(bus_a), 32'd0);
    checkOutput("sb_pending_at_reset", exp_q.size(), 1);
    exp_q.delete();
    busack_n = 1'b1;
    repeat (2) @(posedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
